// File: rtl/register_file_pkg.sv
// Definitions shared between the CPU register-file control block and the register file.
// Holds the pipeline stage and instruction encodings plus the default datapath sizes.
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    STAGE_INSTR_FETCH  = 3'd0,
    STAGE_INSTR_DECODE = 3'd1,
    STAGE_EXECUTE      = 3'd2,
    STAGE_MEM_ACCESS   = 3'd3,
    STAGE_REG_UPDATE   = 3'd4,
    STAGE_PC_UPDATE    = 3'd5
  } stage_t;

  typedef enum logic [1:0] {
    INSTR_NO_OP          = 2'd0,
    INSTR_LOAD_IMMEDIATE = 2'd1,
    INSTR_LOAD           = 2'd2,
    INSTR_ALU_OP         = 2'd3
  } instr_t;

endpackage

// File: rtl/register_file_read_port.sv
// One registered read port: write-to-read bypass, hardwired-zero r0 forcing,
// and the read_enable-gated output register for data and valid.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_reg,
  input  logic [DATA_WIDTH-1:0] stored_data,
  input  logic                  stored_valid,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid
);

  logic zero_hit;
  logic bypass_hit;

  assign zero_hit   = (ZERO_REG != 0) && (read_reg == '0);
  assign bypass_hit = write_enable && (read_reg == write_address);

  // Hardwired r0 outranks bypass so a dropped r0 write never leaks through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else if (read_enable) begin
      if (zero_hit) begin
        read_data  <= '0;
        read_valid <= 1'b1;
      end else if (bypass_hit) begin
        read_data  <= write_data;
        read_valid <= 1'b1;
      end else begin
        read_data  <= stored_data;
        read_valid <= stored_valid;
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register storage with per-register written tracking,
// two registered read ports with bypass, and a combinational debug view.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_reg_0,
  input  logic [ADDR_WIDTH-1:0] read_reg_1,
  output logic [DATA_WIDTH-1:0] read_data_0,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic                  read_valid_0,
  output logic                  read_valid_1,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   written;
  logic                  write_allowed;

  assign write_allowed = write_enable && !((ZERO_REG != 0) && (write_address == '0));

  // A hardwired r0 counts as written from reset onward so its reads report valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      written <= '0;
      if (ZERO_REG != 0) begin
        written[0] <= 1'b1;
      end
    end else if (write_allowed) begin
      regs[write_address]    <= write_data;
      written[write_address] <= 1'b1;
    end
  end

  assign dbg_data = regs[dbg_addr];

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_read_port_0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_enable   (read_enable),
    .read_reg      (read_reg_0),
    .stored_data   (regs[read_reg_0]),
    .stored_valid  (written[read_reg_0]),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .read_data     (read_data_0),
    .read_valid    (read_valid_0)
  );

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_read_port_1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_enable   (read_enable),
    .read_reg      (read_reg_1),
    .stored_data   (regs[read_reg_1]),
    .stored_valid  (written[read_reg_1]),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .read_data     (read_data_1),
    .read_valid    (read_valid_1)
  );

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register storage that consumes the control outputs of the CPU's register-file control logic.
- Control logic drives write_address, write_data, write_enable, read_reg_0 and read_reg_1. This block stores the data and returns two registered read operands to the ALU and memory-address path.
- Also tracks, per register, whether it has been written since reset, so uninitialised-register reads are flagged.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH (32)
- ZERO_REG, 0, when 1 register 0 is hardwired to zero and is never written

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- write_address  input  ADDR_WIDTH  destination register index
- write_data  input  DATA_WIDTH  value to write
- write_enable  input  1  commit write_data to write_address at this edge
- read_enable  input  1  capture new read operands at this edge; 0 = hold outputs
- read_reg_0  input  ADDR_WIDTH  index for operand port 0
- read_reg_1  input  ADDR_WIDTH  index for operand port 1
- read_data_0  output  DATA_WIDTH  registered operand 0
- read_data_1  output  DATA_WIDTH  registered operand 1
- read_valid_0  output  1  registered: operand 0 register had been written (or is hardwired zero)
- read_valid_1  output  1  same for port 1
- dbg_addr  input  ADDR_WIDTH  debug/verification read index
- dbg_data  output  DATA_WIDTH  combinational current contents of dbg_addr (no bypass)

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all registers cleared to 0 and all written bits cleared;
  - if ZERO_REG=1, r0's written bit is forced to 1;
  - read_data_0/1 = 0 and read_valid_0/1 = 0.
  - Reset has priority over write_enable and read_enable in the same cycle. A write presented during reset is dropped.
- Write:
  - When rst_n=1 and write_enable=1, regs[write_address] <= write_data and written[write_address] <= 1 at the edge.
  - When ZERO_REG=1 and write_address=0, the write is ignored and r0 stays 0.
- Read, latency 1:
  - When read_enable=1, read_data_N <= value of regs[read_reg_N] and read_valid_N <= written[read_reg_N].
  - When read_enable=0, both outputs hold their previous values.
- Write-to-read bypass:
  - Applies when write_enable=1, read_enable=1 and read_reg_N == write_address in the same cycle.
  - read_data_N takes write_data (the new value) and read_valid_N = 1.
  - Bypass is suppressed for r0 when ZERO_REG=1; the port returns 0 with valid 1.
- Both ports may name the same register. Both return identical data, including the bypass case.
- A read of r0 with ZERO_REG=1 always returns 0 and valid 1.
- dbg_data reflects stored contents only. A write becomes visible on dbg_data in the cycle after its edge.
- No internal state machine beyond storage, written bits and output registers. The control block already limits write_enable to the register-update stage; this block does not check stages.
- No X propagation is permitted on outputs after reset. All indices are in range by construction (NUM_REGS = 2**ADDR_WIDTH).

Decomposition:
- Shared package/header holds:
  - STAGE_INSTR_FETCH..STAGE_PC_UPDATE;
  - INSTR_NO_OP, INSTR_LOAD_IMMEDIATE, INSTR_LOAD, INSTR_ALU_OP;
  - default DATA_WIDTH/ADDR_WIDTH constants.
  - The control block and this block use these same definitions.
- Sub-module register_file_read_port, instantiated twice, contains:
  - the bypass compare/mux,
  - ZERO_REG forcing,
  - the read_enable-gated output register for data and valid.
  Storage and written bits stay in the top module.

Test Plan:
- Reset then read r7 with read_enable=1 -> next cycle read_data_0=0, read_valid_0=0; dbg_data for every index = 0.
- Write r3=0xDEADBEEF in cycle N; in N+1 read r3 on both ports -> in N+2 read_data_0=read_data_1=0xDEADBEEF, valid=1.
- Same-cycle write r5=0x12345678 and read r5 on port 1 -> next cycle read_data_1=0x12345678, read_valid_1=1. dbg_data(r5) shows 0x12345678 only from N+1.
- ZERO_REG=1: write r0=0xFFFFFFFF with same-cycle read r0 -> read_data_0=0, read_valid_0=1; dbg_data(r0)=0.
- read_enable=0 while r3 is rewritten to 0x1 -> read_data_0 holds 0xDEADBEEF until the next read_enable=1 cycle, then shows 0x1.
- Write r9=0xA5A5A5A5 with rst_n=0 in the same cycle -> r9=0 and read_valid=0 afterwards. Outputs are 0 in the cycle after reset regardless of prior values.
